// File: rtl/display_source_scheduler_if.sv
// Signal bundle between the ADC sources, the operator controls and the display-side
// outputs of display_source_scheduler.
interface display_source_scheduler_if #(
    parameter int NUM_SRC = 4
);
    logic [16*NUM_SRC-1:0] src_data;
    logic [NUM_SRC-1:0]    src_valid;
    logic [NUM_SRC-1:0]    src_dec;
    logic [1:0]            manual_sel;
    logic                  auto_mode;
    logic                  freeze;
    logic [15:0]           value;
    logic                  bin_bcd_select;
    logic [1:0]            active_src;
    logic                  overrange;
    logic                  update_strobe;

    modport master (
        output src_data, src_valid, src_dec, manual_sel, auto_mode, freeze,
        input  value, bin_bcd_select, active_src, overrange, update_strobe
    );

    modport slave (
        input  src_data, src_valid, src_dec, manual_sel, auto_mode, freeze,
        output value, bin_bcd_select, active_src, overrange, update_strobe
    );
endinterface

// File: rtl/display_source_scheduler.sv
// Captures the latest sample of each ADC source and refreshes the seven-segment display
// value at a rate-limited tick, choosing the source manually or round-robin.
module display_source_scheduler #(
    parameter int NUM_SRC       = 4,
    parameter int UPDATE_DIV    = 25000000,
    parameter int DWELL_UPDATES = 8,
    parameter int DEC_MAX       = 9999
) (
    input logic                       clk,
    input logic                       reset,
    display_source_scheduler_if.slave bus
);
    localparam int CNT_W = $clog2(UPDATE_DIV);
    localparam int DW_W  = (DWELL_UPDATES > 1) ? $clog2(DWELL_UPDATES) : 1;

    typedef enum logic [1:0] {WAIT_DATA, SHOW, FROZEN} state_t;

    state_t             state;
    logic [15:0]        cap [NUM_SRC];
    logic [NUM_SRC-1:0] seen;
    logic [CNT_W-1:0]   cnt;
    logic [DW_W-1:0]    dwell;
    logic [1:0]         manual_sel_q;
    logic               auto_q;

    logic [15:0] value_r;
    logic        bcd_r, ovr_r, strobe_r;
    logic [1:0]  active_src_r;

    logic        tick, sel_valid, auto_rise;
    logic [3:0]  seen4, eff_seen4;
    logic        any_seen, upd, cnt_clr, rotate;
    logic [1:0]  first_seen, next_seen, upd_sel, cand;
    logic [15:0] upd_data;
    logic        upd_dec, upd_clamp;

    assign tick      = (cnt == CNT_W'(UPDATE_DIV - 1));
    assign sel_valid = (int'(bus.manual_sel) < NUM_SRC);
    assign auto_rise = bus.auto_mode && !auto_q;
    assign seen4     = 4'(seen);
    // While waiting for first data a same-cycle strobe counts, so the first sample shows after one clock.
    assign eff_seen4 = 4'(seen | bus.src_valid);
    assign upd_clamp = upd_dec && (upd_data > 16'(DEC_MAX));

    always_comb begin
        // NOTE: every signal written here gets a default first, so no path can infer a latch.
        upd        = 1'b0;
        cnt_clr    = 1'b0;
        rotate     = 1'b0;
        upd_sel    = active_src_r;
        any_seen   = |eff_seen4;
        first_seen = '0;
        next_seen  = active_src_r;
        cand       = '0;
        upd_data   = '0;
        upd_dec    = 1'b0;

        for (int i = NUM_SRC - 1; i >= 0; i--)
            if (eff_seen4[i]) first_seen = 2'(i);
        // Descending offset so the nearest seen successor wins.
        for (int k = NUM_SRC - 1; k >= 1; k--) begin
            cand = 2'((int'(active_src_r) + k) % NUM_SRC);
            if (seen4[cand]) next_seen = cand;
        end

        case (state)
            WAIT_DATA: begin
                if (bus.auto_mode) begin
                    if (any_seen) begin
                        upd = 1'b1; upd_sel = first_seen; cnt_clr = 1'b1;
                    end
                end else if (sel_valid && eff_seen4[bus.manual_sel]) begin
                    upd = 1'b1; upd_sel = bus.manual_sel; cnt_clr = 1'b1;
                end
            end
            SHOW: begin
                if (!bus.freeze) begin
                    if (!bus.auto_mode) begin
                        if (sel_valid && bus.manual_sel != manual_sel_q) begin
                            upd = 1'b1; upd_sel = bus.manual_sel; cnt_clr = 1'b1;
                        end else if (sel_valid && tick) begin
                            upd = 1'b1; upd_sel = bus.manual_sel;
                        end
                    end else if (tick) begin
                        upd = 1'b1;
                        if (!auto_rise && dwell == DW_W'(DWELL_UPDATES - 1)) begin
                            rotate = 1'b1; upd_sel = next_seen;
                        end
                    end
                end
            end
            default: ;
        endcase

        for (int i = 0; i < NUM_SRC; i++) begin
            if (2'(i) == upd_sel) begin
                upd_data = (state == WAIT_DATA && bus.src_valid[i]) ? bus.src_data[16*i +: 16] : cap[i];
                upd_dec  = bus.src_dec[i];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= WAIT_DATA;
            seen         <= '0;
            cnt          <= '0;
            dwell        <= '0;
            manual_sel_q <= '0;
            auto_q       <= 1'b0;
            value_r      <= '0;
            bcd_r        <= 1'b0;
            ovr_r        <= 1'b0;
            strobe_r     <= 1'b0;
            active_src_r <= '0;
            // NOTE: capture registers are reset too, so a never-seen source displays 0, not stale data.
            for (int i = 0; i < NUM_SRC; i++) cap[i] <= '0;
        end else begin
            // NOTE: non-blocking throughout, so every decision uses the pre-edge register values.
            manual_sel_q <= bus.manual_sel;
            auto_q       <= bus.auto_mode;
            for (int i = 0; i < NUM_SRC; i++) begin
                if (bus.src_valid[i]) begin
                    cap[i]  <= bus.src_data[16*i +: 16];
                    seen[i] <= 1'b1;
                end
            end

            cnt      <= (cnt_clr || tick) ? '0 : cnt + CNT_W'(1);
            strobe_r <= upd;
            if (upd) begin
                value_r      <= upd_clamp ? 16'(DEC_MAX) : upd_data;
                ovr_r        <= upd_clamp;
                bcd_r        <= upd_dec;
                active_src_r <= upd_sel;
            end

            case (state)
                WAIT_DATA: if (upd) state <= SHOW;
                SHOW: begin
                    if (bus.freeze) state <= FROZEN;
                    if (auto_rise || rotate)
                        dwell <= '0;
                    else if (bus.auto_mode && tick && !bus.freeze)
                        dwell <= dwell + DW_W'(1);
                end
                FROZEN: if (!bus.freeze) state <= SHOW;
                default: state <= WAIT_DATA;
            endcase
        end
    end

    assign bus.value          = value_r;
    assign bus.bin_bcd_select = bcd_r;
    assign bus.active_src     = active_src_r;
    assign bus.overrange      = ovr_r;
    assign bus.update_strobe  = strobe_r;
endmodule

// File: tb/tb_display_source_scheduler.sv
// Scoreboard bench: a cycle-level reference model queues every expected display update,
// and a negedge monitor checks each strobe and that outputs hold between updates.
module tb_display_source_scheduler;
  localparam int NUM_SRC = 4, UPDATE_DIV = 10, DWELL_UPDATES = 2, DEC_MAX = 9999;
  localparam int M_WAIT = 0, M_SHOW = 1, M_FROZEN = 2;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   cyc = 0;
  int   total = 0, bad = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  display_source_scheduler_if #(.NUM_SRC(NUM_SRC)) bus ();

  display_source_scheduler #(
    .NUM_SRC(NUM_SRC), .UPDATE_DIV(UPDATE_DIV),
    .DWELL_UPDATES(DWELL_UPDATES), .DEC_MAX(DEC_MAX)
  ) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  typedef struct {
    int cyc;
    int value;
    bit dec;
    int src;
    bit ovr;
  } exp_t;
  exp_t exp_q[$];

  task automatic check(string name, logic [31:0] got, logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, got, want, cyc);
    end
  endtask

  // Reference model: what the display should show, derived from the selection rules.
  int m_cap[NUM_SRC];
  bit m_seen[NUM_SRC];
  int m_mode, m_phase, m_active, m_ticks_on_src, m_prev_sel;
  bit m_prev_auto;

  task automatic model_reset();
    for (int i = 0; i < NUM_SRC; i++) begin m_cap[i] = 0; m_seen[i] = 0; end
    m_mode = M_WAIT; m_phase = 0; m_active = 0; m_ticks_on_src = 0;
    m_prev_sel = 0; m_prev_auto = 0;
  endtask

  task automatic model_step();
    bit tick, rose, upd, forced, found;
    int sel, msel, data;
    exp_t e;
    tick = (m_phase == UPDATE_DIV - 1);
    rose = bus.auto_mode && !m_prev_auto;
    msel = int'(bus.manual_sel);
    upd = 0; forced = 0; sel = m_active; found = 0;
    if (m_mode == M_WAIT) begin
      if (bus.auto_mode) begin
        for (int i = 0; i < NUM_SRC; i++)
          if (!found && (m_seen[i] || bus.src_valid[i])) begin found = 1; sel = i; end
        if (found) begin upd = 1; forced = 1; end
      end else if (m_seen[msel] || bus.src_valid[msel]) begin
        upd = 1; forced = 1; sel = msel;
      end
    end else if (m_mode == M_SHOW) begin
      if (rose) m_ticks_on_src = 0;
      if (bus.freeze) m_mode = M_FROZEN;
      else if (!bus.auto_mode) begin
        if (msel != m_prev_sel) begin upd = 1; forced = 1; sel = msel; end
        else if (tick) begin upd = 1; sel = msel; end
      end else if (tick) begin
        upd = 1;
        if (!rose) begin
          m_ticks_on_src++;
          if (m_ticks_on_src == DWELL_UPDATES) begin
            m_ticks_on_src = 0;
            for (int k = 1; k < NUM_SRC; k++)
              if (!found && m_seen[(m_active + k) % NUM_SRC]) begin
                found = 1; sel = (m_active + k) % NUM_SRC;
              end
          end
        end
      end
    end else if (!bus.freeze) begin
      m_mode = M_SHOW;
    end

    if (upd) begin
      data = (m_mode == M_WAIT && bus.src_valid[sel]) ? int'(bus.src_data[16*sel +: 16]) : m_cap[sel];
      e.cyc = cyc + 1;
      e.dec = bus.src_dec[sel];
      e.ovr = e.dec && (data > DEC_MAX);
      e.value = e.ovr ? DEC_MAX : data;
      e.src = sel;
      exp_q.push_back(e);
      m_active = sel;
      if (m_mode == M_WAIT) m_mode = M_SHOW;
    end
    m_phase = (forced || tick) ? 0 : m_phase + 1;
    for (int i = 0; i < NUM_SRC; i++)
      if (bus.src_valid[i]) begin m_cap[i] = int'(bus.src_data[16*i +: 16]); m_seen[i] = 1; end
    m_prev_sel = msel;
    m_prev_auto = bus.auto_mode;
  endtask

  // Monitor: compares each strobe with the queue head, otherwise checks outputs are held.
  logic [31:0] last_out = '0;
  exp_t        got_e;
  always @(negedge clk) begin
    if (reset) begin
      last_out = '0;
    end else if (bus.update_strobe) begin
      if (exp_q.size() == 0) begin
        check("unexpected_strobe", 32'(bus.active_src), 32'hFFFF_FFFF);
      end else begin
        got_e = exp_q.pop_front();
        check("update_cycle", cyc, got_e.cyc);
        check("value", 32'(bus.value), got_e.value);
        check("bin_bcd_select", 32'(bus.bin_bcd_select), 32'(got_e.dec));
        check("active_src", 32'(bus.active_src), got_e.src);
        check("overrange", 32'(bus.overrange), 32'(got_e.ovr));
        last_out = {got_e.src[1:0], got_e.ovr, got_e.dec, 12'h0, got_e.value[15:0]};
      end
    end else begin
      if (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
        check("missed_strobe", cyc, exp_q[0].cyc);
        exp_q.delete(0);
      end
      check("hold", {bus.active_src, bus.overrange, bus.bin_bcd_select, 12'h0, bus.value}, last_out);
    end
  end

  task automatic step();
    model_step();
    @(posedge clk); #1;
    bus.src_valid = '0;
  endtask

  task automatic idle(int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic send(int s, int d);
    bus.src_data[16*s +: 16] = 16'(d);
    bus.src_valid[s] = 1'b1;
  endtask

  task automatic wait_tick_cycle();
    for (int i = 0; i < UPDATE_DIV && m_phase != UPDATE_DIV - 1; i++) step();
  endtask

  task automatic do_reset(string tag);
    reset = 1'b1;
    #1;
    check({tag, "_value"}, 32'(bus.value), 0);
    check({tag, "_bcd"}, 32'(bus.bin_bcd_select), 0);
    check({tag, "_active"}, 32'(bus.active_src), 0);
    check({tag, "_ovr"}, 32'(bus.overrange), 0);
    check({tag, "_strobe"}, 32'(bus.update_strobe), 0);
    exp_q.delete();
    model_reset();
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  initial begin
    bus.src_data = '0; bus.src_valid = '0; bus.src_dec = '0;
    bus.manual_sel = '0; bus.auto_mode = 1'b0; bus.freeze = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    do_reset("reset_init");

    // No source seen: the display must stay idle.
    idle(25);

    // Manual source 1, decimal, first sample shown one clock after its strobe.
    bus.manual_sel = 2'd1; bus.src_dec = 4'b0010;
    send(1, 16'h1234);
    step();
    check("first_value", 32'(bus.value), 32'h1234);
    check("first_bcd", 32'(bus.bin_bcd_select), 1);
    check("first_active", 32'(bus.active_src), 1);
    check("first_strobe", 32'(bus.update_strobe), 1);
    idle(25);

    // Decimal clamp, then the same sample in hex.
    send(1, 12000); step();
    idle(11);
    check("clamp_value", 32'(bus.value), DEC_MAX);
    check("clamp_ovr", 32'(bus.overrange), 1);
    bus.src_dec = 4'b0000;
    idle(11);
    check("hex_value", 32'(bus.value), 32'h2EE0);
    check("hex_ovr", 32'(bus.overrange), 0);

    // Mid-run reset, then auto rotation over sources 0, 2, 3.
    do_reset("reset_mid");
    bus.auto_mode = 1'b1;
    send(0, 100); send(2, 200); send(3, 300); step();
    idle(80);
    do_reset("reset_auto");
    send(2, 222); step();
    idle(50);
    check("single_src_active", 32'(bus.active_src), 2);

    // Freeze while new samples arrive, release, then freeze on a tick cycle.
    bus.auto_mode = 1'b0; bus.manual_sel = 2'd2;
    idle(3);
    bus.freeze = 1'b1;
    for (int i = 0; i < 30; i++) begin send(2, 1000 + i); step(); end
    check("frozen_value", 32'(bus.value), 222);
    bus.freeze = 1'b0;
    idle(12);
    wait_tick_cycle();
    bus.freeze = 1'b1; step();
    idle(5);
    bus.freeze = 1'b0;
    idle(12);

    // Select change mid-period, then a sample landing on a tick.
    send(0, 11); send(3, 33); step();
    bus.manual_sel = 2'd0; idle(4);
    bus.manual_sel = 2'd3; step();
    check("sel_change_active", 32'(bus.active_src), 3);
    check("sel_change_strobe", 32'(bus.update_strobe), 1);
    idle(4);
    wait_tick_cycle();
    send(3, 4444); step();
    idle(12);

    // Randomized phase.
    for (int n = 0; n < 4000; n++) begin
      for (int s = 0; s < NUM_SRC; s++)
        if ($urandom_range(0, 5) == 0)
          send(s, ($urandom_range(0, 1) != 0) ? $urandom_range(0, 12000) : ($urandom & 16'hFFFF));
      if ($urandom_range(0, 50) == 0) bus.src_dec = 4'($urandom);
      if ($urandom_range(0, 30) == 0) bus.manual_sel = 2'($urandom);
      if ($urandom_range(0, 150) == 0) bus.auto_mode = ~bus.auto_mode;
      if ($urandom_range(0, 60) == 0) bus.freeze = ~bus.freeze;
      if ($urandom_range(0, 900) == 0) begin
        bus.src_valid = '0;
        do_reset("reset_rand");
      end else begin
        step();
      end
    end

    bus.freeze = 1'b1;
    idle(3);
    check("queue_drained", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
